// File: rtl/ball_motion.sv
// Pong ball engine: holds the ball at the serve spot, then moves it one STEP per
// game_tick, bouncing off walls and paddles, detecting misses and keeping the score.
module ball_motion #(
  parameter int POS_X       = 310,
  parameter int POS_Y       = 265,
  parameter int BALL_SIZE   = 10,
  parameter int PAD_W       = 30,
  parameter int PAD_H       = 200,
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int STEP        = 1,
  parameter int SERVE_TICKS = 1000,
  parameter int MAX_SCORE   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic [9:0] p1_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_x,
  input  logic [9:0] p2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       point_p1,
  output logic       point_p2,
  output logic       game_over,
  output logic [1:0] dbg_state,
  output logic       dbg_dir_x,
  output logic       dbg_dir_y
);

  // game_tick is a plain strobe: every cycle it is high counts as one tick, no handshake.
  // dbg_state codes: 0 SERVE, 1 MOVE, 2 SCORED, 3 OVER; dbg_dir_x 1=right, dbg_dir_y 1=down.
  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVE   = 2'd1,
    SCORED = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_TICKS - 1);

  localparam logic [10:0] SIZE_W = 11'(BALL_SIZE);
  localparam logic [10:0] PADW_W = 11'(PAD_W);
  localparam logic [10:0] PADH_W = 11'(PAD_H);
  localparam logic [10:0] SCRW_W = 11'(SCR_W);
  localparam logic [10:0] SCRH_W = 11'(SCR_H);
  localparam logic [10:0] STEP_W = 11'(STEP);

  localparam logic [9:0] POS_X_V = 10'(POS_X);
  localparam logic [9:0] POS_Y_V = 10'(POS_Y);
  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] BOT_Y   = 10'(SCR_H - BALL_SIZE);
  localparam logic [3:0] MAX_V   = 4'(MAX_SCORE);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic          scorer_q, scorer_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          pt1_q, pt1_d, pt2_q, pt2_d;
  logic          go_q, go_d;
  logic          win;

  // 11-bit views so that sums such as x+PAD_W never wrap
  logic [10:0] bx, by, p1x, p1y, p2x, p2y;
  assign bx  = {1'b0, x_q};
  assign by  = {1'b0, y_q};
  assign p1x = {1'b0, p1_x};
  assign p1y = {1'b0, p1_y};
  assign p2x = {1'b0, p2_x};
  assign p2y = {1'b0, p2_y};

  logic       ov1, ov2, hit1, hit2, miss_l, miss_r;
  logic [3:0] s1_inc, s2_inc;

  assign ov1    = (by + SIZE_W > p1y) && (by < p1y + PADH_W);
  assign ov2    = (by + SIZE_W > p2y) && (by < p2y + PADH_W);
  assign hit1   = ov1 && (bx >= p1x + PADW_W) && (bx <= p1x + PADW_W + STEP_W);
  assign hit2   = ov2 && (bx + SIZE_W < p2x) && (bx + SIZE_W + STEP_W >= p2x);
  assign miss_l = (bx < STEP_W);
  assign miss_r = (bx + SIZE_W + STEP_W >= SCRW_W);
  assign s1_inc = (s1_q >= MAX_V) ? MAX_V : s1_q + 4'd1;
  assign s2_inc = (s2_q >= MAX_V) ? MAX_V : s2_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SERVE;
      cnt_q    <= '0;
      x_q      <= POS_X_V;
      y_q      <= POS_Y_V;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      scorer_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      scorer_q <= scorer_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pt1_q    <= pt1_d;
      pt2_q    <= pt2_d;
      go_q     <= go_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    scorer_d = scorer_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    pt1_d    = 1'b0;
    pt2_d    = 1'b0;
    go_d     = go_q;
    win      = 1'b0;
    case (state_q)
      SERVE: begin
        x_d = POS_X_V;
        y_d = POS_Y_V;
        if (game_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = MOVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      MOVE: begin
        if (game_tick) begin
          if (!dir_y_q) begin
            if (by < STEP_W) begin
              y_d     = '0;
              dir_y_d = 1'b1;
            end else begin
              y_d = y_q - STEP_V;
            end
          end else if (by + SIZE_W + STEP_W > SCRH_W) begin
            y_d     = BOT_Y;
            dir_y_d = 1'b0;
          end else begin
            y_d = y_q + STEP_V;
          end
          // A paddle hit takes priority over a miss on the same side
          if (!dir_x_q) begin
            if (hit1) begin
              x_d     = 10'(p1x + PADW_W + 11'd1);
              dir_x_d = 1'b1;
            end else if (miss_l) begin
              scorer_d = 1'b0;
              state_d  = SCORED;
            end else begin
              x_d = x_q - STEP_V;
            end
          end else begin
            if (hit2) begin
              x_d     = 10'(p2x - SIZE_W - 11'd1);
              dir_x_d = 1'b0;
            end else if (miss_r) begin
              scorer_d = 1'b1;
              state_d  = SCORED;
            end else begin
              x_d = x_q + STEP_V;
            end
          end
        end
      end
      SCORED: begin
        x_d   = POS_X_V;
        y_d   = POS_Y_V;
        cnt_d = '0;
        // Next serve travels toward the player who just conceded
        if (scorer_q) begin
          s1_d    = s1_inc;
          pt1_d   = 1'b1;
          dir_x_d = 1'b1;
          win     = (s1_inc == MAX_V);
        end else begin
          s2_d    = s2_inc;
          pt2_d   = 1'b1;
          dir_x_d = 1'b0;
          win     = (s2_inc == MAX_V);
        end
        go_d    = win;
        state_d = win ? OVER : SERVE;
      end
      OVER: begin
        x_d  = POS_X_V;
        y_d  = POS_Y_V;
        go_d = 1'b1;
      end
      default: state_d = SERVE;
    endcase
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign score_p1  = s1_q;
  assign score_p2  = s2_q;
  assign point_p1  = pt1_q;
  assign point_p2  = pt2_q;
  assign game_over = go_q;
  assign dbg_state = state_q;
  assign dbg_dir_x = dir_x_q;
  assign dbg_dir_y = dir_y_q;

endmodule
